// File: rtl/pp_dma_pkg.sv
// pp_dma_pkg: shared constants for the ping-pong DMA engine.
//   FSM state encodings (IDLE/RUN/ABORT/FIN) and the word stride used for
//   both the source and destination address pointers.
package pp_dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/pp_dma_fifo.sv
// pp_dma_fifo: synchronous read-data buffer for pp_dma_engine.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : write an entry (accepted when not full, or when popping)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the buffer; overrides push/pop
//   head_c     : current head entry
//   next_c     : entry behind the head (valid when count >= 2)
//   full_c     : buffer full
//   empty_c    : buffer empty
//   count      : number of stored entries
module pp_dma_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic [WIDTH-1:0]         next_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_c, do_pop_c;

  // Pointer/count update; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_c  = pop && (count_q != '0);
    do_push_c = push && ((count_q != CW'(DEPTH)) || do_pop_c);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign next_c  = mem_q[rd_ptr_q + AW'(1)];
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/pp_dma_engine.sv
// pp_dma_engine: single-channel memory-to-memory DMA with a credit-limited
// read-data buffer.
//   clk, rst          : clock, asynchronous active-high reset
//   SDAddr/SDCounts/DestAddr : source address, word count, destination address
//                       (captured when a transfer starts)
//   DMAEN[0]          : rising edge starts (IDLE only), falling edge aborts
//   rd_req/rd_addr    : source read request, held until rd_gnt
//   rd_valid/rd_data  : in-order read returns
//   wr_req/wr_addr/wr_data : destination write request, held until wr_gnt
//   busy              : RUN or ABORT
//   done              : one-cycle pulse on normal completion
// Optional (`define PP_DMA_IRQ_EN): dma_irq (sticky completion interrupt,
// set on FIN with priority) and irq_clr (clears dma_irq).
module pp_dma_engine
  import pp_dma_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] SDAddr,
  input  logic [31:0] SDCounts,
  input  logic [31:0] DestAddr,
  input  logic [31:0] DMAEN,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_gnt,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_gnt,
  output logic        busy,
  output logic        done
`ifdef PP_DMA_IRQ_EN
  ,
  output logic        dma_irq,
  input  logic        irq_clr
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic          en_prev_q;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   rd_rem_q, rd_rem_d;
  logic [31:0]   wr_rem_q, wr_rem_d;
  logic [CW-1:0] out_q, out_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start_c, rd_fire_c, wr_fire_c, rd_ret_c;
  logic          fifo_push_c, fifo_flush_c;
  logic [CW-1:0] cnt_d;
  logic [31:0]   fifo_head_c, fifo_next_c;
  logic          fifo_full_c, fifo_empty_c;
  logic [CW-1:0] fifo_count;
  logic          dmaen_unused_c;

  pp_dma_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push_c),
    .pop     (wr_fire_c),
    .flush   (fifo_flush_c),
    .wdata   (rd_data),
    .head_c  (fifo_head_c),
    .next_c  (fifo_next_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count   (fifo_count)
  );

  // Next-state, counters, pointers and registered outputs.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_rem_d  = rd_rem_q;
    wr_rem_d  = wr_rem_q;

    dmaen_unused_c = ^DMAEN[31:1];
    start_c      = DMAEN[0] && !en_prev_q;
    rd_fire_c    = rd_req_q && rd_gnt;
    wr_fire_c    = wr_req_q && wr_gnt;
    rd_ret_c     = rd_valid && (out_q != '0);
    // Returns arriving outside RUN (i.e. while aborting) are dropped.
    fifo_push_c  = rd_valid && (state_q == ST_RUN) && (!fifo_full_c || wr_fire_c);
    fifo_flush_c = (state_q == ST_ABORT);

    out_d = out_q + CW'(rd_fire_c) - CW'(rd_ret_c);
    cnt_d = fifo_count + CW'(fifo_push_c) - CW'(wr_fire_c);
    if (fifo_flush_c) cnt_d = '0;

    // wr_data tracks what the buffer head will be after this edge.
    if (wr_fire_c) begin
      if (fifo_count > CW'(1))  wr_data_d = fifo_next_c;
      else if (fifo_push_c)     wr_data_d = rd_data;
    end else if (fifo_empty_c && fifo_push_c) begin
      wr_data_d = rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          rd_addr_d = SDAddr;
          wr_addr_d = DestAddr;
          rd_rem_d  = SDCounts;
          wr_rem_d  = SDCounts;
          state_d   = (SDCounts == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_fire_c) begin
          rd_addr_d = rd_addr_q + WORD_STRIDE;
          rd_rem_d  = rd_rem_q - 32'd1;
        end
        if (wr_fire_c) begin
          wr_addr_d = wr_addr_q + WORD_STRIDE;
          wr_rem_d  = wr_rem_q - 32'd1;
        end
        // Completion of the final write takes precedence over an abort.
        if (wr_fire_c && (wr_rem_q == 32'd1)) state_d = ST_FIN;
        else if (!DMAEN[0])                   state_d = ST_ABORT;
      end
      ST_ABORT: begin
        if (out_d == '0) state_d = ST_IDLE;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Credit: never have more reads in flight plus buffered than buffer slots.
    rd_req_d = (state_d == ST_RUN) && (rd_rem_d != '0) &&
               ((32'(out_d) + 32'(cnt_d)) < 32'(BUF_DEPTH));
    wr_req_d = (state_d == ST_RUN) && (cnt_d != '0);
    busy_d   = (state_d == ST_RUN) || (state_d == ST_ABORT);
    done_d   = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      en_prev_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_rem_q  <= '0;
      wr_rem_q  <= '0;
      out_q     <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_prev_q <= DMAEN[0];
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_rem_q  <= rd_rem_d;
      wr_rem_q  <= wr_rem_d;
      out_q     <= out_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef PP_DMA_IRQ_EN
  logic irq_q, irq_d;

  // Sticky interrupt; a completion in the same cycle as a clear wins.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr)            irq_d = 1'b0;
    if (state_q == ST_FIN)  irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign dma_irq = irq_q;
`endif

endmodule

// File: tb/tb_pp_dma_engine.sv
module tb_pp_dma_engine;

  localparam int unsigned BUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] SDAddr, SDCounts, DestAddr, DMAEN;
  logic        rd_req, rd_gnt, rd_valid;
  logic [31:0] rd_addr, rd_data;
  logic        wr_req, wr_gnt;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done;
`ifdef PP_DMA_IRQ_EN
  logic        dma_irq, irq_clr;
`endif

  pp_dma_engine #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .SDAddr   (SDAddr),
    .SDCounts (SDCounts),
    .DestAddr (DestAddr),
    .DMAEN    (DMAEN),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .busy     (busy),
    .done     (done)
`ifdef PP_DMA_IRQ_EN
    ,
    .dma_irq  (dma_irq),
    .irq_clr  (irq_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [31:0] exp_rd[$];
  wr_exp_t     exp_wr[$];
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  int rd_pct = 100, wr_pct = 100, lat_min = 1, lat_max = 1;
  bit wr_hold = 1'b0;
  int done_cnt = 0, wr_fire_cnt = 0, rd_gnt_cnt = 0;
  int wr_req_cyc = 0, rd_req_cyc = 0, busy_cyc = 0;
  bit done_prev = 1'b0;

  // Source memory contents as a function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Source/destination bus responder: grants, in-order returns with latency.
  initial begin
    rd_gnt = 1'b0; wr_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        rd_gnt = 1'b0; wr_gnt = 1'b0; rd_valid = 1'b0;
      end else begin
        rd_valid = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          rd_valid = 1'b1;
          rd_data  = mem_fn(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        rd_gnt = 1'b0;
        if (rd_req && ($urandom_range(99) < rd_pct)) begin
          rd_gnt = 1'b1;
          rd_gnt_cnt++;
          if (exp_rd.size() == 0) fail("rd_unexpected", $sformatf("read granted at 0x%08h with none expected", rd_addr));
          else chk("rd_addr", rd_addr, exp_rd.pop_front());
          pend_addr.push_back(rd_addr);
          pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        end
        wr_gnt = wr_req && !wr_hold && ($urandom_range(99) < wr_pct);
      end
    end
  end

  // Monitor: compares every accepted write against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        done_prev = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          if (done_prev) fail("done_width", "done high for two consecutive cycles");
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        done_prev = done;
        if (wr_req) wr_req_cyc++;
        if (rd_req) rd_req_cyc++;
        if (busy)   busy_cyc++;
        if (wr_req && wr_gnt) begin
          wr_exp_t e;
          wr_fire_cnt++;
          if (exp_wr.size() == 0) begin
            fail("wr_unexpected", $sformatf("write to 0x%08h with none expected", wr_addr));
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
      end
    end
  end

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] a;
      a = src + 32'(i) * 32'd4;
      exp_rd.push_back(a);
      exp_wr.push_back('{addr: dst + 32'(i) * 32'd4, data: mem_fn(a)});
    end
    SDAddr = src; DestAddr = dst; SDCounts = n;
    DMAEN  = {31'($urandom()), 1'b1};
    tick(1);
    if (n != 0) chk("busy_run", 32'(busy), 32'd1);
    // Register inputs must no longer matter once the transfer has started.
    SDAddr = $urandom(); DestAddr = $urandom(); SDCounts = $urandom();
  endtask

  task automatic wait_done(input string name, input int base, input int budget);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      tick(1);
      k++;
    end
    tick(3);
    chk({name, "_done_count"}, 32'(done_cnt - base), 32'd1);
    chk({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    DMAEN = 32'h0;
    tick(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, k, rq, wq, bc, gb, wb;
    logic [31:0] src, dst, n;
    rst = 1'b1;
    SDAddr = '0; SDCounts = '0; DestAddr = '0; DMAEN = '0;
`ifdef PP_DMA_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick(3);
    chk("rst_rd_req",  32'(rd_req), 32'd0);
    chk("rst_wr_req",  32'(wr_req), 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
`ifdef PP_DMA_IRQ_EN
    chk("rst_dma_irq", 32'(dma_irq), 32'd0);
`endif
    rst = 1'b0;
    tick(2);

    // Basic 4-word copy, single-cycle read latency
    b = done_cnt;
    start_xfer(32'h100, 32'h200, 32'd4);
    wait_done("basic", b, 200);

`ifdef PP_DMA_IRQ_EN
    chk("irq_after_fin", 32'(dma_irq), 32'd1);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(dma_irq), 32'd0);
`endif

    // Zero-length transfer: straight to FIN, no bus activity
    b = done_cnt; rq = rd_req_cyc; wq = wr_req_cyc; bc = busy_cyc;
    SDAddr = 32'h40; DestAddr = 32'h80; SDCounts = 32'd0; DMAEN = 32'h1;
    k = 0;
    while (done_cnt == b && k < 10) begin
      tick(1);
      k++;
    end
    chk("zero_done_within_2", 32'((k >= 1) && (k <= 2)), 32'd1);
    tick(3);
    chk("zero_done_count", 32'(done_cnt - b), 32'd1);
    chk("zero_no_rd_req", 32'(rd_req_cyc - rq), 32'd0);
    chk("zero_no_wr_req", 32'(wr_req_cyc - wq), 32'd0);
    chk("zero_busy_low",  32'(busy_cyc - bc), 32'd0);
    DMAEN = 32'h0;
    tick(2);

    // Edge while not enabled-low: holding DMAEN high must not restart
    b = done_cnt;
    start_xfer(32'h500, 32'h600, 32'd2);
    wait_done("short", b, 200);

    // Destination stalled: credit limit bounds reads before first write
    b = done_cnt; gb = rd_gnt_cnt; wb = wr_fire_cnt;
    wr_hold = 1'b1;
    start_xfer(32'h1000, 32'h8000, 32'd10);
    tick(19);
    chk("stall_reads_eq_depth", 32'(rd_gnt_cnt - gb), 32'(BUF_DEPTH));
    chk("stall_no_writes", 32'(wr_fire_cnt - wb), 32'd0);
    wr_hold = 1'b0;
    wait_done("stall", b, 400);

    // Abort after the third write, reads still in flight
    rd_pct = 100; wr_pct = 100; lat_min = 3; lat_max = 3;
    b = done_cnt; wb = wr_fire_cnt;
    start_xfer(32'h2000, 32'h3000, 32'd8);
    k = 0;
    while (wr_fire_cnt < wb + 3 && k < 200) begin
      tick(1);
      k++;
    end
    DMAEN[0] = 1'b0;
    wr_hold  = 1'b1;
    chk("abort_at_third_write", 32'(wr_fire_cnt - wb), 32'd3);
    rq = rd_req_cyc; wq = wr_req_cyc;
    tick(1);
    k = 0;
    while (busy && k < 50) begin
      tick(1);
      k++;
    end
    chk("abort_to_idle", 32'(busy), 32'd0);
    chk("abort_reads_drained", 32'(pend_addr.size()), 32'd0);
    chk("abort_no_wr_req", 32'(wr_req_cyc - wq), 32'd0);
    chk("abort_no_rd_req", 32'(rd_req_cyc - rq), 32'd0);
    tick(3);
    chk("abort_no_done", 32'(done_cnt - b), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    wr_hold = 1'b0;
    DMAEN = 32'h0;
    tick(2);

    // Follow-up transfer must not see any discarded data
    lat_min = 1; lat_max = 3;
    b = done_cnt;
    start_xfer(32'h4000, 32'h5000, 32'd6);
    wait_done("post_abort", b, 300);

    // Source address wraps modulo 2^32
    lat_min = 1; lat_max = 1;
    b = done_cnt;
    start_xfer(32'hFFFF_FFF8, 32'h0000_0700, 32'd3);
    wait_done("wrap", b, 200);

    // Reset in the middle of a transfer
    rd_pct = 70; wr_pct = 60; lat_min = 1; lat_max = 3;
    b = done_cnt;
    start_xfer(32'h6000, 32'h7000, 32'd16);
    tick(6);
    rst = 1'b1;
    DMAEN = 32'h0;
    #1;
    chk("midrst_busy",    32'(busy), 32'd0);
    chk("midrst_rd_req",  32'(rd_req), 32'd0);
    chk("midrst_wr_req",  32'(wr_req), 32'd0);
    chk("midrst_rd_addr", rd_addr, 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("midrst_no_done", 32'(done_cnt - b), 32'd0);
    chk("midrst_idle",    32'(busy), 32'd0);

`ifdef PP_DMA_IRQ_EN
    // Completion and clear in the same cycle: completion wins
    b = done_cnt;
    SDCounts = 32'd0; DMAEN = 32'h1; irq_clr = 1'b1;
    tick(2);
    chk("irq_set_wins", 32'(dma_irq), 32'd1);
    tick(1);
    chk("irq_clear_next", 32'(dma_irq), 32'd0);
    irq_clr = 1'b0;
    chk("irq_done_count", 32'(done_cnt - b), 32'd1);
    DMAEN = 32'h0;
    tick(2);
`endif

    // Randomized transfers with random bus back-pressure and latency
    for (int t = 0; t < 20; t++) begin
      rd_pct  = $urandom_range(100, 30);
      wr_pct  = $urandom_range(100, 30);
      lat_min = 1;
      lat_max = $urandom_range(4, 1);
      n   = 32'($urandom_range(24, 1));
      src = $urandom() & 32'hFFFF_FFFC;
      dst = $urandom() & 32'hFFFF_FFFC;
      b = done_cnt;
      start_xfer(src, dst, n);
      wait_done("rand", b, 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_dma_engine.md
PP_DMA_ENGINE -- requirements
Module: pp_dma_engine

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 4, read-data buffer entries (power of 2, 2..16).
REQ-002 SHALL have ports in this order:
  clk  in  1  sole clock.
  rst  in  1  asynchronous, active-high reset.
  SDAddr  in  32  source start byte address (word aligned).
  SDCounts  in  32  number of 32-bit words to move.
  DestAddr  in  32  destination start byte address (word aligned).
  DMAEN  in  32  bit0 = enable; bits 31:1 ignored.
  rd_req  out  1  source read request.
  rd_addr  out  32  source read address.
  rd_gnt  in  1  read request accepted this cycle.
  rd_valid  in  1  read data returned, in request order.
  rd_data  in  32  read data.
  wr_req  out  1  destination write request.
  wr_addr  out  32  destination write address.
  wr_data  out  32  write data.
  wr_gnt  in  1  write accepted this cycle.
  busy  out  1  transfer in progress.
  done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL start a transfer on a rising edge of DMAEN[0] (registered previous value) only in IDLE; edges in other states are ignored.
REQ-004 SHALL sample SDAddr, SDCounts, DestAddr at start; later changes do not affect the transfer.
REQ-005 SHALL implement states IDLE, RUN, ABORT, FIN.
REQ-006 SHALL transition IDLE->RUN on start with SDCounts!=0; IDLE->FIN on start with SDCounts==0 (no bus activity).
REQ-007 SHALL assert rd_req in RUN while reads remaining>0 and (outstanding reads + buffer occupancy)<BUF_DEPTH; rd_addr/rd_req held stable until rd_gnt.
REQ-008 SHALL increment rd_addr by 4 and decrement reads remaining on each rd_gnt; 32-bit address wrap at 0xFFFFFFFC->0 is plain modulo.
REQ-009 SHALL push rd_data into buffer on rd_valid; rd_valid never overflows buffer due to REQ-007 credit rule.
REQ-010 SHALL assert wr_req whenever buffer non-empty in RUN, wr_data = buffer head, wr_addr = current destination; on wr_gnt pop head, wr_addr += 4.
REQ-011 SHALL permit push and pop in the same cycle, occupancy unchanged; rd_valid data may be written no earlier than the cycle after it is pushed.
REQ-012 SHALL go RUN->FIN when the last write is granted; FIN lasts one cycle with done=1, then IDLE.
REQ-013 SHALL go RUN->ABORT if DMAEN[0] falls: no new rd_req, no new wr_req, buffer flushed, outstanding read returns discarded; ABORT->IDLE when outstanding==0; done not pulsed.
REQ-014 SHALL drive busy=1 in RUN and ABORT, 0 in IDLE and FIN.
REQ-015 SHALL use 32-bit remaining/count registers; SDCounts up to 0xFFFFFFFF supported.

Reset
REQ-016 SHALL on rst: state IDLE, rd_req=0, wr_req=0, rd_addr=0, wr_addr=0, wr_data=0, busy=0, done=0, buffer empty, outstanding=0, DMAEN edge register=0.
REQ-017 SHALL, on rst mid-transfer, abandon the transfer immediately; no completion reported.

Configuration
REQ-018 SHALL, with PP_DMA_IRQ_EN defined, add ports dma_irq (out, 1) and irq_clr (in, 1): dma_irq sets on FIN, clears on irq_clr (set wins if simultaneous), reset 0.
REQ-019 SHALL, without PP_DMA_IRQ_EN, omit both ports; all other behaviour identical.

Structure
REQ-020 SHALL place state encodings and word-stride constant (4) in shared package pp_dma_pkg.
REQ-021 SHALL implement the buffer as sub-module pp_dma_fifo (sync FIFO, push/pop/full/empty/count).

Verification
REQ-022 SDCounts=4, SDAddr=0x100, DestAddr=0x200, gnts always 1, rd_valid 1 cycle after gnt -> writes 0x200..0x20C carry data from 0x100..0x10C in order, one done pulse.
REQ-023 SDCounts=0, DMAEN 0->1 -> no rd_req/wr_req, done pulse 2 cycles after edge, busy stays 0.
REQ-024 SDCounts=10, wr_gnt held 0 for 20 cycles -> at most BUF_DEPTH=4 rd_gnt before first wr_gnt; all 10 words delivered after release.
REQ-025 SDCounts=8, DMAEN[0] dropped after 3rd write with 2 reads outstanding -> ABORT, no further wr_req, IDLE after 2 rd_valid, no done.
REQ-026 SDAddr=0xFFFFFFF8, SDCounts=3 -> rd_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-027 PP_DMA_IRQ_EN defined, transfer ends same cycle irq_clr=1 -> dma_irq=1; irq_clr next cycle -> dma_irq=0.
